// File: rtl/timer_clint_pkg.sv
// Shared constants and helpers for the memory-mapped machine timer / software-interrupt block.
package timer_clint_pkg;

  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;

  localparam logic [11:0] CLINT_MSIP        = 12'h000;
  localparam logic [11:0] CLINT_CTRL        = 12'h004;
  localparam logic [11:0] CLINT_MTIMECMP_LO = 12'h008;
  localparam logic [11:0] CLINT_MTIMECMP_HI = 12'h00C;
  localparam logic [11:0] CLINT_MTIME_LO    = 12'h010;
  localparam logic [11:0] CLINT_MTIME_HI    = 12'h014;

  localparam int unsigned REG_IDX_W = 10;

  localparam logic [REG_IDX_W-1:0] IDX_MSIP        = CLINT_MSIP[11:2];
  localparam logic [REG_IDX_W-1:0] IDX_CTRL        = CLINT_CTRL[11:2];
  localparam logic [REG_IDX_W-1:0] IDX_MTIMECMP_LO = CLINT_MTIMECMP_LO[11:2];
  localparam logic [REG_IDX_W-1:0] IDX_MTIMECMP_HI = CLINT_MTIMECMP_HI[11:2];
  localparam logic [REG_IDX_W-1:0] IDX_MTIME_LO    = CLINT_MTIME_LO[11:2];
  localparam logic [REG_IDX_W-1:0] IDX_MTIME_HI    = CLINT_MTIME_HI[11:2];

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Bus request payload as seen by the register block.
  typedef struct packed {
    logic                 sel;
    logic                 op;
    logic [REG_IDX_W-1:0] idx;
    logic [3:0]           mask;
    logic [31:0]          wdata;
  } clint_req_t;

  // Byte-lane merge: lanes with mask=1 take wdata, others keep old.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  mask);
    logic [31:0] bmask;
    bmask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    return (old_val & ~bmask) | (wdata & bmask);
  endfunction

endpackage

// File: rtl/timer_clint_if.sv
// Data-bus port of the timer block plus its interrupt outputs.
interface timer_clint_if;
  logic        io_sel;
  logic [31:0] io_addr;
  logic        io_op;
  logic [3:0]  io_mask;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_timer_irq;
  logic        io_soft_irq;
  logic        io_interrupt;

  modport master (
    output io_sel, io_addr, io_op, io_mask, io_wdata,
    input  io_rdata, io_timer_irq, io_soft_irq, io_interrupt
  );

  modport slave (
    input  io_sel, io_addr, io_op, io_mask, io_wdata,
    output io_rdata, io_timer_irq, io_soft_irq, io_interrupt
  );
endinterface

// File: rtl/timer_prescaler.sv
// Free-running divider: counts 0..PRESCALE-1 while enabled, holds when disabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= (count_q == CNT_MAX) ? '0 : count_q + CNT_W'(1);
    end
  end

  assign tick_c = en && (count_q == CNT_MAX);

endmodule

// File: rtl/timer_clint.sv
// Machine timer (64-bit mtime/mtimecmp) and MSIP software interrupt on the data bus.
// Define TIMER_SHADOW_READ_EN to latch mtime[63:32] on MTIME_LO reads for atomic 64-bit reads.
module timer_clint
  import timer_clint_pkg::*;
#(
  parameter int unsigned PRESCALE       = 100,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  timer_clint_if.slave  bus
);

  clint_req_t  req;
  logic        wr_c;
  logic        rd_c;
  logic        mtime_wr_c;
  logic        tick_c;
  logic        unused_addr_bits;

  logic [63:0] mtime_q,     mtime_d;
  logic [63:0] mtimecmp_q,  mtimecmp_d;
  logic        msip_q,      msip_d;
  logic        en_q,        en_d;
  logic        timer_irq_q, timer_irq_d;
  logic        intr_q,      intr_d;
  logic [31:0] rdata_q,     rdata_d;

  assign req = '{sel:   bus.io_sel,
                 op:    bus.io_op,
                 idx:   bus.io_addr[11:2],
                 mask:  bus.io_mask,
                 wdata: bus.io_wdata};

  assign unused_addr_bits = ^{bus.io_addr[31:12], bus.io_addr[1:0]};

  assign wr_c       = req.sel && (req.op == OP_WRITE);
  assign rd_c       = req.sel && (req.op == OP_READ);
  assign mtime_wr_c = wr_c && ((req.idx == IDX_MTIME_LO) || (req.idx == IDX_MTIME_HI));

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en_q),
    .tick_c (tick_c)
  );

`ifdef TIMER_SHADOW_READ_EN
  logic [31:0] shadow_q;

  // Capture the pre-increment HI alongside the LO value being returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (rd_c && (req.idx == IDX_MTIME_LO)) begin
      shadow_q <= mtime_q[63:32];
    end
  end
`else
  logic unused_rd;
  assign unused_rd = rd_c;
`endif

  // Next-state for register file, compare and read mux.
  always_comb begin
    msip_d     = msip_q;
    en_d       = en_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    rdata_d    = '0;

    if (wr_c) begin
      case (req.idx)
        IDX_MSIP:        if (req.mask[0]) msip_d = req.wdata[0];
        IDX_CTRL:        if (req.mask[0]) en_d   = req.wdata[0];
        IDX_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  req.wdata, req.mask);
        IDX_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req.wdata, req.mask);
        IDX_MTIME_LO:    mtime_d[31:0]     = merge_bytes(mtime_q[31:0],     req.wdata, req.mask);
        IDX_MTIME_HI:    mtime_d[63:32]    = merge_bytes(mtime_q[63:32],    req.wdata, req.mask);
        default: ;
      endcase
    end

    // A software write to either mtime half suppresses the whole increment.
    if (tick_c && !mtime_wr_c) begin
      mtime_d = mtime_q + 64'd1;
    end

    case (req.idx)
      IDX_MSIP:        rdata_d = {31'd0, msip_q};
      IDX_CTRL:        rdata_d = {31'd0, en_q};
      IDX_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
      IDX_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
      IDX_MTIME_LO:    rdata_d = mtime_q[31:0];
`ifdef TIMER_SHADOW_READ_EN
      IDX_MTIME_HI:    rdata_d = shadow_q;
`else
      IDX_MTIME_HI:    rdata_d = mtime_q[63:32];
`endif
      default:         rdata_d = '0;
    endcase

    timer_irq_d = (mtime_q >= mtimecmp_q);
    intr_d      = timer_irq_d | msip_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RESET;
      msip_q      <= 1'b0;
      en_q        <= 1'b1;
      timer_irq_q <= 1'b0;
      intr_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      en_q        <= en_d;
      timer_irq_q <= timer_irq_d;
      intr_q      <= intr_d;
      rdata_q     <= rdata_d;
    end
  end

  // Interrupt is its own flop fed by the OR of the next irq values, so it never glitches.
  assign bus.io_rdata     = rdata_q;
  assign bus.io_timer_irq = timer_irq_q;
  assign bus.io_soft_irq  = msip_q;
  assign bus.io_interrupt = intr_q;

endmodule

// File: tb/tb_timer_clint.sv
// Directed bench for timer_clint with a cycle model and hand-computed checkpoints.
module tb_timer_clint;

  localparam int unsigned PRESCALE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;

  timer_clint_if bif ();

  timer_clint #(
    .PRESCALE       (PRESCALE),
    .MTIMECMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_cnt <= rst ? 0 : edge_cnt + 1;

  // Reference model: register state evolved from the documented rules.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_en, m_tirq;
  logic [31:0] m_rdata, m_shadow;
  int unsigned m_pcount;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [11:0] off;
    logic [63:0] n_mtime, n_cmp;
    logic [31:0] rv;
    logic        wr, rd, tick;
    if (rst) begin
      m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0; m_en = 1'b1;
      m_tirq = 1'b0; m_rdata = 32'd0; m_shadow = 32'd0; m_pcount = 0; m_valid = 1'b1;
    end else begin
      off = {bif.io_addr[11:2], 2'b00};
      wr  = bif.io_sel && bif.io_op;
      rd  = bif.io_sel && !bif.io_op;
      case (off)
        12'h000: rv = {31'd0, m_msip};
        12'h004: rv = {31'd0, m_en};
        12'h008: rv = m_cmp[31:0];
        12'h00C: rv = m_cmp[63:32];
        12'h010: rv = m_mtime[31:0];
`ifdef TIMER_SHADOW_READ_EN
        12'h014: rv = m_shadow;
`else
        12'h014: rv = m_mtime[63:32];
`endif
        default: rv = 32'd0;
      endcase
      tick = m_en && (m_pcount == PRESCALE - 1);
      n_mtime = m_mtime;
      n_cmp = m_cmp;
      if (wr && off == 12'h010)      n_mtime[31:0]  = lanes(m_mtime[31:0], bif.io_wdata, bif.io_mask);
      else if (wr && off == 12'h014) n_mtime[63:32] = lanes(m_mtime[63:32], bif.io_wdata, bif.io_mask);
      else if (tick)                 n_mtime = m_mtime + 64'd1;
      if (wr && off == 12'h008) n_cmp[31:0]  = lanes(m_cmp[31:0], bif.io_wdata, bif.io_mask);
      if (wr && off == 12'h00C) n_cmp[63:32] = lanes(m_cmp[63:32], bif.io_wdata, bif.io_mask);
      if (rd && off == 12'h010) m_shadow = m_mtime[63:32];
      m_tirq  = (m_mtime >= m_cmp);
      m_rdata = rv;
      if (m_en) m_pcount = (m_pcount + 1) % PRESCALE;
      if (wr && off == 12'h000 && bif.io_mask[0]) m_msip = bif.io_wdata[0];
      if (wr && off == 12'h004 && bif.io_mask[0]) m_en = bif.io_wdata[0];
      m_mtime = n_mtime;
      m_cmp   = n_cmp;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("rdata", 64'(bif.io_rdata), 64'(m_rdata));
      chk("timer_irq", 64'(bif.io_timer_irq), 64'(m_tirq));
      chk("soft_irq", 64'(bif.io_soft_irq), 64'(m_msip));
      chk("interrupt", 64'(bif.io_interrupt), 64'(m_tirq | m_msip));
    end
  end

  task automatic idle();
    bif.io_sel = 1'b0; bif.io_op = 1'b0; bif.io_mask = 4'h0;
  endtask

  task automatic bus_write(input logic [11:0] off, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bif.io_sel = 1'b1; bif.io_op = 1'b1; bif.io_addr = {20'd0, off};
    bif.io_wdata = d; bif.io_mask = m;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic bus_read(input string name, input logic [11:0] off, input logic [31:0] exp);
    @(negedge clk);
    bif.io_sel = 1'b1; bif.io_op = 1'b0; bif.io_addr = {20'd0, off};
    @(posedge clk); #1;
    chk(name, 64'(bif.io_rdata), 64'(exp));
    idle();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bif.io_addr = 32'd0; bif.io_wdata = 32'd0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", 64'(bif.io_rdata), 64'd0);
    chk("reset_intr", 64'(bif.io_interrupt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_reset_timer_irq", 64'(bif.io_timer_irq), 64'd0);
    chk("post_reset_intr", 64'(bif.io_interrupt), 64'd0);

    // Reads captured on edges 2..7; first tick at edge 4 so mtime=1.
    bus_read("rd_msip", 12'h000, 32'd0);
    bus_read("rd_ctrl", 12'h004, 32'd1);
    bus_read("rd_cmp_lo", 12'h008, 32'hFFFF_FFFF);
    bus_read("rd_cmp_hi", 12'h00C, 32'hFFFF_FFFF);
    bus_read("rd_mtime_lo", 12'h010, 32'd1);
    bus_read("rd_mtime_hi", 12'h014, 32'd0);

    // mtimecmp=10: mtime hits 10 on edge 40, irq on edge 41.
    bus_write(12'h008, 32'd10, 4'hF);
    bus_write(12'h00C, 32'd0, 4'hF);
    for (int i = 0; i < 200 && edge_cnt < 40; i++) step();
    chk("irq_before_41", 64'(bif.io_timer_irq), 64'd0);
    step();
    chk("irq_at_41", 64'(bif.io_timer_irq), 64'd1);
    chk("intr_at_41", 64'(bif.io_interrupt), 64'd1);
    bus_write(12'h008, 32'hFFFF_FFFF, 4'hF);
    chk("irq_on_cmp_write_edge", 64'(bif.io_timer_irq), 64'd1);
    step();
    chk("irq_cleared", 64'(bif.io_timer_irq), 64'd0);
    bus_write(12'h00C, 32'hFFFF_FFFF, 4'hF);

    // Land the LO write on a tick edge, then watch the carry.
    for (int i = 0; i < 8 && (edge_cnt % 4) != 3; i++) step();
    bus_write(12'h010, 32'hFFFF_FFFF, 4'hF);
    bus_write(12'h014, 32'd0, 4'hF);
    bus_read("mtime_lo_write_wins", 12'h010, 32'hFFFF_FFFF);
    bus_read("mtime_hi_pre_carry", 12'h014, 32'd0);
    step();
    bus_read("mtime_lo_after_carry", 12'h010, 32'd0);
    bus_read("mtime_hi_after_carry", 12'h014, 32'd1);

    bus_write(12'h008, 32'h1122_3344, 4'hF);
    bus_write(12'h008, 32'h0000_AB00, 4'b0010);
    bus_read("masked_cmp_lo", 12'h008, 32'h1122_AB44);

    bus_write(12'h000, 32'd1, 4'h1);
    chk("msip_soft_hi", 64'(bif.io_soft_irq), 64'd1);
    chk("msip_intr_hi", 64'(bif.io_interrupt), 64'd1);
    bus_write(12'h000, 32'd0, 4'h1);
    chk("msip_soft_lo", 64'(bif.io_soft_irq), 64'd0);
    chk("msip_intr_lo", 64'(bif.io_interrupt), 64'd0);

    // Disabled timer holds a written value for 1000 cycles.
    bus_write(12'h004, 32'd0, 4'h1);
    bus_write(12'h010, 32'h55, 4'hF);
    bus_write(12'h014, 32'd0, 4'hF);
    repeat (1000) step();
    bus_read("frozen_lo", 12'h010, 32'h55);
    bus_read("frozen_hi", 12'h014, 32'd0);
    bus_read("ctrl_off", 12'h004, 32'd0);

    bus_write(12'h020, 32'hDEAD_BEEF, 4'hF);
    bus_read("unmapped_20", 12'h020, 32'd0);
    bus_read("unmapped_18", 12'h018, 32'd0);

    // LO read on a tick edge with mtime=0x1_FFFFFFFF.
    bus_write(12'h004, 32'd1, 4'h1);
    bus_write(12'h014, 32'd1, 4'hF);
    for (int i = 0; i < 8 && m_pcount != 2; i++) step();
    bus_write(12'h010, 32'hFFFF_FFFF, 4'hF);
    bus_read("atomic_lo", 12'h010, 32'hFFFF_FFFF);
`ifdef TIMER_SHADOW_READ_EN
    bus_read("atomic_hi_shadow", 12'h014, 32'd1);
`else
    bus_read("atomic_hi_live", 12'h014, 32'd2);
`endif

    // Reset beats a same-cycle write.
    bus_write(12'h000, 32'd1, 4'h1);
    @(negedge clk);
    rst = 1'b1;
    bif.io_sel = 1'b1; bif.io_op = 1'b1; bif.io_addr = 32'd0;
    bif.io_wdata = 32'd1; bif.io_mask = 4'hF;
    step();
    chk("reset_over_write_soft", 64'(bif.io_soft_irq), 64'd0);
    chk("reset_over_write_intr", 64'(bif.io_interrupt), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    bus_read("after_reset_ctrl", 12'h004, 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
